apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB3 master that converts the single-cycle command strobes produced by the UART command parser (`w <addr> <data>` / `r <addr>`) into compliant APB SETUP/ACCESS transfers and returns read data to the parser. Sits directly downstream of the UART parser and upstream of the APB peripheral fabric. Buffers one pending command while a transfer is in flight, enforces a PREADY timeout, and substitutes an error word on failed reads.

## Interface
- `TIMEOUT`, 1024: max ACCESS cycles waiting for PREADY; 0 disables timeout.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on PSLVERR or timeout.
- `iCLK` input 1: sole clock, rising edge.
- `iRESET` input 1: asynchronous, active-high reset.
- `iCMD_WRITE` input 1: 1-cycle write command strobe from parser.
- `iCMD_READ` input 1: 1-cycle read command strobe from parser.
- `iCMD_ADDR` input 16: command address, valid with strobe.
- `iCMD_WDATA` input 32: write data, valid with iCMD_WRITE.
- `oRDATA_EN` output 1: 1-cycle pulse, read result valid.
- `oRDATA` output 32: read result; held until next oRDATA_EN.
- `oBUSY` output 1: transfer in flight or command pending.
- `oDROP` output 1: 1-cycle pulse, a command was discarded.
- `oPSEL`, `oPENABLE`, `oPWRITE` output 1 each: APB control.
- `oPADDR` output 16, `oPWDATA` output 32: APB address/write data.
- `iPREADY` input 1, `iPSLVERR` input 1, `iPRDATA` input 32: APB response.

## Operation
- States: IDLE, SETUP, ACCESS. IDLE -> SETUP when a command is available (new strobe or pending slot). SETUP -> ACCESS unconditionally. ACCESS holds until iPREADY=1 or timeout, then -> SETUP if pending slot full, else IDLE.
- Command capture: strobe sampled on rising edge; addr/wdata/direction latched with it. If IDLE and slot empty, the command launches directly; otherwise it goes to the one-entry pending slot.
- Slot full and new strobe: new command discarded, oDROP pulses; slot contents unchanged.
- iCMD_WRITE and iCMD_READ in same cycle: write accepted, read discarded, oDROP pulses.
- Strobe in same cycle the slot is being drained into SETUP: slot refills with the new command; not dropped.
- Read completion: oRDATA = iPRDATA if iPSLVERR=0, else ERR_DATA. Timeout: oRDATA = ERR_DATA. oRDATA_EN pulses in both cases.
- Write completion (including error/timeout): no response to parser, no oRDATA_EN.
- Timeout counter: clears on entering ACCESS, increments each ACCESS cycle with iPREADY=0; reaching TIMEOUT ends the transfer (PSEL/PENABLE deassert next cycle). Width $clog2(TIMEOUT+1).
- oPADDR/oPWDATA/oPWRITE stable from SETUP through final ACCESS cycle; oPADDR passed unmodified (no alignment).
- oBUSY = state != IDLE or slot full.

## Timing
- Reset (async assert): all outputs 0, oRDATA=0, state IDLE, slot empty, counter 0. Reset mid-transfer: bus idles immediately, in-flight and pending commands lost, no oRDATA_EN.
- Strobe at edge N (IDLE, empty): SETUP in cycle N+1 (PSEL=1, PENABLE=0), ACCESS from N+2 (PENABLE=1).
- Zero-wait read: iPREADY=1 in first ACCESS cycle (N+2); oRDATA_EN=1 and oRDATA valid in cycle N+3.
- Back-to-back: pending command's SETUP in the cycle immediately after completing ACCESS (no IDLE gap).
- oDROP and oRDATA_EN are registered, one cycle wide.

## Structure
- Shared package `apb_cmd_pkg`: state enum (IDLE/SETUP/ACCESS), command record (dir, addr[15:0], wdata[31:0]), default ERR_DATA constant.
- One sub-module `apb_cmd_slot`: one-entry command holding register with load/drain/full and drop generation; FSM, timeout counter and response logic stay in the top.

## Test plan
- Read 0xF000, slave PRDATA=0x1234_5678, PREADY=1 immediately -> PSEL N+1, PENABLE N+2, oRDATA_EN N+3 with 0x1234_5678.
- Write 0x1234 data 0x5A5A_5A5A, PREADY after 3 wait cycles -> PADDR/PWDATA/PWRITE stable over 5 bus cycles, no oRDATA_EN.
- Read 0xF004 with PSLVERR=1 on ready -> oRDATA=0xDEAD_BEEF, oRDATA_EN one pulse.
- TIMEOUT=8, slave never ready, read 0x4321 -> ACCESS for 8 cycles, then bus idle, oRDATA=ERR_DATA.
- Three strobes on consecutive cycles with slow slave -> first in flight, second pending, third oDROP; second's SETUP immediately follows first's completion.
- Reset asserted during ACCESS with slot full -> outputs 0 asynchronously, after release oBUSY=0 and no oRDATA_EN.

Source files
------------

// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM states, the command record
// and the default error word returned on failed reads.
package apb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic        dir;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic        DIR_READ         = 1'b0;
    localparam logic        DIR_WRITE        = 1'b1;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // A simultaneous write+read strobe resolves to the write.
    function automatic cmd_t make_cmd(input logic        wr,
                                      input logic [15:0] addr,
                                      input logic [31:0] wdata);
        cmd_t c;
        c.dir   = wr ? DIR_WRITE : DIR_READ;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/apb_cmd_slot.sv
// One-entry pending command register. Refills in the same cycle it drains,
// and flags any command that arrives while it is full and not draining.
module apb_cmd_slot
    import apb_cmd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic drain,
    input  logic dual,
    input  cmd_t cmd_in,
    output logic full,
    output cmd_t cmd,
    output logic drop
);

    // Slot occupancy, contents and registered drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            cmd  <= '0;
            drop <= 1'b0;
        end else begin
            drop <= dual | (push & full & ~drain);
            if (drain) begin
                full <= push;
                if (push) begin
                    cmd <= cmd_in;
                end
            end else if (push && !full) begin
                full <= 1'b1;
                cmd  <= cmd_in;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 master turning UART parser command strobes into SETUP/ACCESS transfers,
// with one pending command, a PREADY timeout and error-word substitution.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iCMD_WRITE,
    input  logic        iCMD_READ,
    input  logic [15:0] iCMD_ADDR,
    input  logic [31:0] iCMD_WDATA,
    output logic        oRDATA_EN,
    output logic [31:0] oRDATA,
    output logic        oBUSY,
    output logic        oDROP,
    output logic        oPSEL,
    output logic        oPENABLE,
    output logic        oPWRITE,
    output logic [15:0] oPADDR,
    output logic [31:0] oPWDATA,
    input  logic        iPREADY,
    input  logic        iPSLVERR,
    input  logic [31:0] iPRDATA
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             psel_r, penable_r, pwrite_r, rdata_en_r;
    logic [15:0]      paddr_r;
    logic [31:0]      pwdata_r, rdata_r;

    logic strobe_s, dual_s, tout_s, done_s, direct_s, drain_s, push_s;
    logic slot_full_s, slot_drop_s;
    cmd_t new_cmd_s, slot_cmd_s, launch_cmd_s;

    // Command arbitration: launch directly, drain the slot, or park in the slot.
    always_comb begin
        strobe_s  = iCMD_WRITE | iCMD_READ;
        dual_s    = iCMD_WRITE & iCMD_READ;
        new_cmd_s = make_cmd(iCMD_WRITE, iCMD_ADDR, iCMD_WDATA);
        if (TIMEOUT != 0) begin
            tout_s = (cnt_r == CNT_LAST) && !iPREADY;
        end else begin
            tout_s = 1'b0;
        end
        done_s       = (state_r == ST_ACCESS) && (iPREADY || tout_s);
        direct_s     = (state_r == ST_IDLE) && !slot_full_s && strobe_s;
        drain_s      = slot_full_s && ((state_r == ST_IDLE) || done_s);
        push_s       = strobe_s && !direct_s;
        launch_cmd_s = slot_full_s ? slot_cmd_s : new_cmd_s;
    end

    apb_cmd_slot u_slot (
        .clk    (iCLK),
        .rst    (iRESET),
        .push   (push_s),
        .drain  (drain_s),
        .dual   (dual_s),
        .cmd_in (new_cmd_s),
        .full   (slot_full_s),
        .cmd    (slot_cmd_s),
        .drop   (slot_drop_s)
    );

    // Transfer FSM with registered bus outputs, timeout counter and read response.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= 16'h0000;
            pwdata_r   <= 32'h0000_0000;
            rdata_en_r <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            rdata_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (drain_s || direct_s) begin
                        state_r   <= ST_SETUP;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        pwrite_r  <= launch_cmd_s.dir;
                        paddr_r   <= launch_cmd_s.addr;
                        pwdata_r  <= launch_cmd_s.wdata;
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                    cnt_r     <= '0;
                end
                ST_ACCESS: begin
                    if (done_s) begin
                        if (pwrite_r == DIR_READ) begin
                            rdata_en_r <= 1'b1;
                            rdata_r    <= (iPREADY && !iPSLVERR) ? iPRDATA : ERR_DATA;
                        end
                        penable_r <= 1'b0;
                        // Pending command goes straight to SETUP, no idle gap.
                        if (slot_full_s) begin
                            state_r  <= ST_SETUP;
                            pwrite_r <= slot_cmd_s.dir;
                            paddr_r  <= slot_cmd_s.addr;
                            pwdata_r <= slot_cmd_s.wdata;
                        end else begin
                            state_r <= ST_IDLE;
                            psel_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    assign oPSEL     = psel_r;
    assign oPENABLE  = penable_r;
    assign oPWRITE   = pwrite_r;
    assign oPADDR    = paddr_r;
    assign oPWDATA   = pwdata_r;
    assign oRDATA_EN = rdata_en_r;
    assign oRDATA    = rdata_r;
    assign oDROP     = slot_drop_s;
    assign oBUSY     = (state_r != ST_IDLE) | slot_full_s;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a per-cycle vector table for the basic
// transfers plus hand-written timeout, pending/drop and reset sequences.
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_write, cmd_read;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rdata_en, busy, drop, psel, penable, pwrite;
    logic [31:0] rdata, pwdata, prdata;
    logic [15:0] paddr;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_cmd_master #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .iCLK       (clk),
        .iRESET     (rst),
        .iCMD_WRITE (cmd_write),
        .iCMD_READ  (cmd_read),
        .iCMD_ADDR  (cmd_addr),
        .iCMD_WDATA (cmd_wdata),
        .oRDATA_EN  (rdata_en),
        .oRDATA     (rdata),
        .oBUSY      (busy),
        .oDROP      (drop),
        .oPSEL      (psel),
        .oPENABLE   (penable),
        .oPWRITE    (pwrite),
        .oPADDR     (paddr),
        .oPWDATA    (pwdata),
        .iPREADY    (pready),
        .iPSLVERR   (pslverr),
        .iPRDATA    (prdata)
    );

    typedef struct {
        logic        wr, rd;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        rdy, err;
        logic [31:0] prd;
        logic        e_psel, e_pen, e_pwrite;
        logic [15:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_ren;
        logic [31:0] e_rdata;
        logic        e_busy, e_drop;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] addr,
                                input logic [31:0] wdata, input logic rdy, input logic err,
                                input logic [31:0] prd, input logic e_psel, input logic e_pen,
                                input logic e_pwrite, input logic [15:0] e_paddr,
                                input logic [31:0] e_pwdata, input logic e_ren,
                                input logic [31:0] e_rdata, input logic e_busy,
                                input logic e_drop);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.rdy = rdy; v.err = err; v.prd = prd;
        v.e_psel = e_psel; v.e_pen = e_pen; v.e_pwrite = e_pwrite;
        v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_ren = e_ren;
        v.e_rdata = e_rdata; v.e_busy = e_busy; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d);
        cmd_write = wr;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    vec_t vecs[17];
    int   n;

    initial begin
        rst = 1'b1;
        set_cmd(1'b0, 1'b0, 16'h0000, 32'h0);
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;

        vecs[0]  = mk(1'b0,1'b1,16'hF000,32'h0,        1'b1,1'b0,32'h1234_5678, 1'b1,1'b0,1'b0,16'hF000,32'h0,         1'b0,32'h0,         1'b1,1'b0);
        vecs[1]  = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,32'h1234_5678, 1'b1,1'b1,1'b0,16'hF000,32'h0,         1'b0,32'h0,         1'b1,1'b0);
        vecs[2]  = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,32'h1234_5678, 1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b1,32'h1234_5678, 1'b0,1'b0);
        vecs[3]  = mk(1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b0,32'h1234_5678, 1'b0,1'b0);
        vecs[4]  = mk(1'b1,1'b0,16'h1234,32'h5A5A_5A5A,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b1,16'h1234,32'h5A5A_5A5A, 1'b0,32'h1234_5678, 1'b1,1'b0);
        vecs[5]  = mk(1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,32'h0,         1'b1,1'b1,1'b1,16'h1234,32'h5A5A_5A5A, 1'b0,32'h1234_5678, 1'b1,1'b0);
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = vecs[5];
        vecs[9]  = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b0,32'h1234_5678, 1'b0,1'b0);
        vecs[10] = mk(1'b0,1'b1,16'hF004,32'h0,        1'b1,1'b1,32'hFFFF_0000, 1'b1,1'b0,1'b0,16'hF004,32'h0,         1'b0,32'h1234_5678, 1'b1,1'b0);
        vecs[11] = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b1,32'hFFFF_0000, 1'b1,1'b1,1'b0,16'hF004,32'h0,         1'b0,32'h1234_5678, 1'b1,1'b0);
        vecs[12] = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b1,32'hFFFF_0000, 1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b1,32'hDEAD_BEEF, 1'b0,1'b0);
        vecs[13] = mk(1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b0,32'hDEAD_BEEF, 1'b0,1'b0);
        vecs[14] = mk(1'b1,1'b1,16'h0042,32'h1111_2222,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,16'h0042,32'h1111_2222, 1'b0,32'hDEAD_BEEF, 1'b1,1'b1);
        vecs[15] = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,32'h0,         1'b1,1'b1,1'b1,16'h0042,32'h1111_2222, 1'b0,32'hDEAD_BEEF, 1'b1,1'b0);
        vecs[16] = mk(1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,32'h5555_5555, 1'b0,1'b0,1'b0,16'h0000,32'h0,         1'b0,32'hDEAD_BEEF, 1'b0,1'b0);

        #12;
        check("reset_outputs", {psel, penable, pwrite, rdata_en, busy, drop, paddr},
              {6'b0, 16'h0000});
        check("reset_data", {rdata, pwdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: zero-wait read, 3-wait write, PSLVERR read, dual strobe.
        for (int i = 0; i < 17; i++) begin
            set_cmd(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            pready = vecs[i].rdy; pslverr = vecs[i].err; prdata = vecs[i].prd;
            tick();
            check($sformatf("vec%0d", i),
                  {psel, penable, rdata_en, busy, drop, psel & pwrite,
                   psel ? paddr : 16'h0000, rdata},
                  {vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_ren, vecs[i].e_busy,
                   vecs[i].e_drop, vecs[i].e_psel & vecs[i].e_pwrite,
                   vecs[i].e_psel ? vecs[i].e_paddr : 16'h0000, vecs[i].e_rdata});
            if (vecs[i].e_psel && vecs[i].e_pwrite) begin
                check($sformatf("vec%0d_pwdata", i), pwdata, vecs[i].e_pwdata);
            end
        end
        set_cmd(1'b0, 1'b0, 16'h0000, 32'h0);
        pslverr = 1'b0;

        // Timeout: slave never ready, expect exactly 8 ACCESS cycles.
        pready = 1'b0;
        set_cmd(1'b0, 1'b1, 16'h4321, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0000, 32'h0);
        check("tmo_setup", {psel, penable, paddr}, {1'b1, 1'b0, 16'h4321});
        tick();
        n = 0;
        while (penable && n < 20) begin
            n++;
            tick();
        end
        check("tmo_access_cycles", n, 8);
        check("tmo_end", {psel, rdata_en, busy}, 3'b010);
        check("tmo_rdata", rdata, 32'hDEAD_BEEF);
        tick();

        // Three consecutive strobes: in flight, pending, dropped.
        set_cmd(1'b0, 1'b1, 16'h0100, 32'h0);
        tick();
        check("ts_a_setup", {psel, penable, paddr}, {1'b1, 1'b0, 16'h0100});
        set_cmd(1'b1, 1'b0, 16'h0200, 32'hB0B0_B0B0);
        tick();
        check("ts_a_access", {psel, penable, busy, drop, paddr}, {4'b1110, 16'h0100});
        set_cmd(1'b0, 1'b1, 16'h0300, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0000, 32'h0);
        check("ts_c_drop", {drop, penable, paddr}, {1'b1, 1'b1, 16'h0100});
        tick();
        check("ts_drop_once", {drop, busy}, 2'b01);
        tick();
        tick();
        pready = 1'b1; prdata = 32'hAAAA_0001;
        tick();
        check("ts_b_setup", {psel, penable, pwrite, rdata_en, paddr}, {4'b1011, 16'h0200});
        check("ts_a_rdata", rdata, 32'hAAAA_0001);
        check("ts_b_pwdata", pwdata, 32'hB0B0_B0B0);
        tick();
        check("ts_b_access", {psel, penable, pwrite, paddr}, {3'b111, 16'h0200});
        tick();
        check("ts_b_done", {psel, penable, busy, rdata_en}, 4'b0000);
        tick();
        check("ts_c_absent", {psel, busy}, 2'b00);

        // Reset during ACCESS with the slot full.
        pready = 1'b0;
        set_cmd(1'b0, 1'b1, 16'h0500, 32'h0);
        tick();
        set_cmd(1'b0, 1'b1, 16'h0600, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 16'h0000, 32'h0);
        check("rst_pre", {psel, penable, busy}, 3'b111);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {psel, penable, pwrite, rdata_en, busy, drop, paddr},
              {6'b0, 16'h0000});
        check("rst_async_data", {rdata, pwdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst_after%0d", k), {psel, penable, busy, rdata_en, drop}, 5'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
